debouncer: RTL and testbench
============================

// Module: debouncer
//
// PURPOSE
//   Receive-side counterpart of the pulse lengthener. It takes a slow, noisy,
//   asynchronous level (push-button, jumper, external strobe) and synchronises it.
//   It debounces the level and emits a clean stable level plus single-cycle
//   rise/fall strobes.
//   It also counts accepted rising events for software/debug visibility.
//   Sits between board-level inputs and control logic that expects one-cycle triggers.
//
// PARAMETERS
//   DEBOUNCE_CYCLES  (1<<20)  consecutive stable synchronised samples required to accept a change; >=1
//   SYNC_STAGES      3        synchroniser flop count; >=2
//   CNT_WIDTH        16       width of accepted-rising-event counter
//
// PORTS
//   clk         in   1          clock
//   rst         in   1          reset, synchronous, active-high
//   in_async    in   1          raw asynchronous input
//   clr_events  in   1          synchronous clear of events counter
//   level       out  1          debounced level
//   rise        out  1          1-cycle strobe on accepted 0->1
//   fall        out  1          1-cycle strobe on accepted 1->0
//   events      out  CNT_WIDTH  accepted rising edges, saturating
//
// BEHAVIOUR
//   - Reset: sync chain=0, state=S_LOW, dcnt=0, level=0, rise=0, fall=0, events=0.
//     Reset mid-check aborts the check: no strobe is emitted for the aborted change.
//   - Sync: SYNC_STAGES flops, all reset to 0; s = last stage.
//   - dcnt width = $clog2(DEBOUNCE_CYCLES)+1.
//   - FSM, 4 states:
//       S_LOW:      s=1 -> S_LOW_CHK, dcnt<=DEBOUNCE_CYCLES-1
//       S_LOW_CHK:  s=0 -> S_LOW (glitch rejected, no strobe)
//                   else dcnt==0 -> S_HIGH, rise<=1
//                   else dcnt<=dcnt-1
//       S_HIGH:     s=0 -> S_HIGH_CHK, dcnt<=DEBOUNCE_CYCLES-1
//       S_HIGH_CHK: s=1 -> S_HIGH (glitch rejected)
//                   else dcnt==0 -> S_LOW, fall<=1
//                   else dcnt<=dcnt-1
//   - level = state in {S_HIGH, S_HIGH_CHK}. level is registered and changes in
//     the same cycle the strobe asserts.
//   - rise and fall are registered, high exactly 1 cycle, and never both high.
//     Minimum spacing between strobes is DEBOUNCE_CYCLES+1 cycles.
//   - Latency: in_async is first sampled high at edge k and held. rise and level=1
//     are visible after edge k+SYNC_STAGES+DEBOUNCE_CYCLES. Fall latency is symmetric.
//   - DEBOUNCE_CYCLES=1: one sample in the CHK state suffices.
//   - events update rules:
//       clr_events & rise      -> 1
//       clr_events only        -> 0
//       rise & events!=all-1s  -> +1
//       rise & events==all-1s  -> hold (saturate, no wrap)
//   - Input held high through reset release: the input is treated as a new rise.
//     It is debounced normally and produces rise and events=1.
//
// STRUCTURE
//   - Shared package/header debounce_pkg: FSM state encodings (S_LOW=2'd0,
//     S_LOW_CHK=2'd1, S_HIGH=2'd2, S_HIGH_CHK=2'd3).
//   - One sub-module: sync_chain #(.STAGES(SYNC_STAGES)) (in -> out, reset to 0).
//     It is reusable by the pulse lengthener's trigger path.
//   - The rest (FSM, dcnt, strobes, events counter) stays in this module.
//
// TESTING  (DEBOUNCE_CYCLES=4, SYNC_STAGES=3, CNT_WIDTH=4)
//   1. Clean press: in_async 0->1 at edge 10, held
//      -> rise=1 and level=1 after edge 17, rise=0 after edge 18, events=1.
//   2. Glitch: in_async high for 3 cycles then low
//      -> rise never asserts, level=0, events=0. Repeat for the 1->0 glitch while high.
//   3. Clean release after case 1: in_async 1->0 held
//      -> single-cycle fall 7 cycles later, level=0, events stays 1.
//   4. Saturation: 17 clean press/release cycles -> events=4'hF, no wrap.
//      Then clr_events in the same cycle as rise -> events=1.
//      Then clr_events alone -> events=0.
//   5. Reset mid-check: rst for 1 cycle while in S_LOW_CHK with in_async held high
//      -> all outputs 0, no rise during reset.
//      rise is asserted SYNC_STAGES+DEBOUNCE_CYCLES cycles after the first post-reset sampling edge.
//   6. Random bounce (period < 4 cycles) for 200 cycles, then stable
//      -> exactly one strobe. Scoreboard checks rise/fall alternate and are never simultaneous.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the input debouncer: FSM state encodings and a
// helper that decodes the debounced level from a state.
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_LOW_CHK  = 2'd1,
        S_HIGH     = 2'd2,
        S_HIGH_CHK = 2'd3
    } state_e;

    // The accepted level stays high while a falling change is still being checked.
    function automatic logic is_high_state(input state_e st);
        return (st == S_HIGH) || (st == S_HIGH_CHK);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a slow asynchronous level. All stages clear to 0
// on reset; the output is the last stage. Also used on the trigger path of the
// pulse lengthener.
module sync_chain #(
    parameter int STAGES = 32'd2
) (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic out_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the synchroniser flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], in_i};
        end
    end

    assign out_o = sync_q[STAGES-1];

endmodule

// File: rtl/debouncer.sv
// Debouncer: synchronises a noisy asynchronous level, accepts a change only
// after DEBOUNCE_CYCLES consecutive stable samples, and produces a clean
// level, one-cycle rise/fall strobes and a saturating count of accepted rises.
module debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 32'd1 << 20,
    parameter int          SYNC_STAGES     = 32'd3,
    parameter int          CNT_WIDTH       = 32'd16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_async,
    input  logic                 clr_events,
    output logic                 level,
    output logic                 rise,
    output logic                 fall,
    output logic [CNT_WIDTH-1:0] events
);

    localparam int            DCNT_W    = $clog2(DEBOUNCE_CYCLES) + 32'd1;
    localparam [DCNT_W-1:0]   DCNT_LOAD = DCNT_W'(DEBOUNCE_CYCLES - 32'd1);

    logic                 sync_s;
    state_e               state_q, state_d;
    logic [DCNT_W-1:0]    dcnt_q, dcnt_d;
    logic                 level_q, level_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic [CNT_WIDTH-1:0] events_q, events_d;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .in_i  (in_async),
        .out_o (sync_s)
    );

    // Debounce FSM: a change is accepted once the count of stable samples expires.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            S_LOW: begin
                if (sync_s) begin
                    state_d = S_LOW_CHK;
                    dcnt_d  = DCNT_LOAD;
                end else begin
                    state_d = S_LOW;
                end
            end
            S_LOW_CHK: begin
                if (!sync_s) begin
                    state_d = S_LOW;
                end else if (dcnt_q == '0) begin
                    state_d = S_HIGH;
                    rise_d  = 1'b1;
                end else begin
                    dcnt_d = dcnt_q - DCNT_W'(32'd1);
                end
            end
            S_HIGH: begin
                if (!sync_s) begin
                    state_d = S_HIGH_CHK;
                    dcnt_d  = DCNT_LOAD;
                end else begin
                    state_d = S_HIGH;
                end
            end
            S_HIGH_CHK: begin
                if (sync_s) begin
                    state_d = S_HIGH;
                end else if (dcnt_q == '0) begin
                    state_d = S_LOW;
                    fall_d  = 1'b1;
                end else begin
                    dcnt_d = dcnt_q - DCNT_W'(32'd1);
                end
            end
            default: begin
                state_d = S_LOW;
                dcnt_d  = '0;
            end
        endcase
        level_d = is_high_state(state_d);
    end

    // Accepted-rise counter, driven from the registered strobe so a clear
    // issued while rise is visible still counts that rise.
    always_comb begin
        events_d = events_q;
        if (clr_events && rise_q) begin
            events_d = CNT_WIDTH'(32'd1);
        end else if (clr_events) begin
            events_d = '0;
        end else if (rise_q && (events_q != '1)) begin
            events_d = events_q + CNT_WIDTH'(32'd1);
        end else begin
            events_d = events_q;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_LOW;
            dcnt_q   <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            events_q <= '0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            events_q <= events_d;
        end
    end

    assign level  = level_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign events = events_q;

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for the debouncer (DEBOUNCE_CYCLES=4, SYNC_STAGES=3,
// CNT_WIDTH=4): a table of per-cycle vectors plus hand-written sequences.
module tb_debouncer;

    localparam int DC = 4;
    localparam int SS = 3;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          in_async;
    logic          clr_events;
    logic          level;
    logic          rise;
    logic          fall;
    logic [CW-1:0] events;

    int checks;
    int errors;
    int n_rise;
    int n_fall;
    bit last_rise;

    typedef struct {
        logic          in_v;
        logic          clr_v;
        logic          lvl;
        logic          r;
        logic          f;
        logic [CW-1:0] ev;
    } vec_t;

    vec_t vq[$];

    debouncer #(
        .DEBOUNCE_CYCLES (DC),
        .SYNC_STAGES     (SS),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_async   (in_async),
        .clr_events (clr_events),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .events     (events)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic in_v, input logic clr_v, input logic lvl,
                                input logic r, input logic f, input logic [CW-1:0] ev,
                                input int n);
        vec_t v;
        v.in_v = in_v; v.clr_v = clr_v; v.lvl = lvl; v.r = r; v.f = f; v.ev = ev;
        for (int i = 0; i < n; i++) vq.push_back(v);
    endfunction

    // One clock edge, sample 1 time unit later, and run the strobe scoreboard.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rise === 1'b1 && fall === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL strobe_both actual=rise1_fall1 required=at_most_one");
        end else if (rise === 1'b1) begin
            n_rise++;
            check("alt_rise", 32'(last_rise), 32'd0);
            last_rise = 1'b1;
        end else if (fall === 1'b1) begin
            n_fall++;
            check("alt_fall", 32'(last_rise), 32'd1);
            last_rise = 1'b0;
        end
        if (rst) last_rise = 1'b0;
    endtask

    initial begin
        int r0;
        int f0;
        int cyc;
        logic val;
        int exp_ev;

        checks = 0; errors = 0; n_rise = 0; n_fall = 0; last_rise = 1'b0;
        rst = 1'b1; in_async = 1'b0; clr_events = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_level",  32'(level),  32'd0);
        check("rst_rise",   32'(rise),   32'd0);
        check("rst_fall",   32'(fall),   32'd0);
        check("rst_events", 32'(events), 32'd0);
        rst = 1'b0;

        // Table: in, clr -> level, rise, fall, events after the edge
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2);   // idle
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 7);   // clean press, counting
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1);   // rise 7 edges after first sample
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 3);   // strobe gone, events=1
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 7);   // clean release, counting
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1);   // fall
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 2);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 3);   // 3-cycle high glitch
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 8);   // rejected
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 7);   // second press
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 3);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 3);   // 3-cycle low glitch
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 8);   // rejected, still high
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 7);   // release
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 2);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1);   // clr_events alone
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1);

        foreach (vq[i]) begin
            in_async   = vq[i].in_v;
            clr_events = vq[i].clr_v;
            tick();
            check($sformatf("v%0d_level", i),  32'(level),  32'(vq[i].lvl));
            check($sformatf("v%0d_rise", i),   32'(rise),   32'(vq[i].r));
            check($sformatf("v%0d_fall", i),   32'(fall),   32'(vq[i].f));
            check($sformatf("v%0d_events", i), 32'(events), 32'(vq[i].ev));
        end
        clr_events = 1'b0;

        // Saturation: 17 clean press/release cycles
        r0 = n_rise;
        for (int p = 0; p < 17; p++) begin
            in_async = 1'b1;
            repeat (9) tick();
            in_async = 1'b0;
            repeat (9) tick();
            exp_ev = (p + 1 > 15) ? 15 : p + 1;
            check($sformatf("sat_events_%0d", p), 32'(events), 32'(exp_ev));
        end
        check("sat_rise_count", 32'(n_rise - r0), 32'd17);

        // clr_events while rise is visible -> 1, then clr alone -> 0
        in_async = 1'b1;
        for (int t = 0; t < 20 && rise !== 1'b1; t++) tick();
        check("clr_rise_seen", 32'(rise), 32'd1);
        check("clr_pre_events", 32'(events), 32'd15);
        clr_events = 1'b1;
        tick();
        check("clr_with_rise", 32'(events), 32'd1);
        tick();
        check("clr_alone", 32'(events), 32'd0);
        clr_events = 1'b0;
        in_async = 1'b0;
        repeat (10) tick();
        check("pre_rst_level", 32'(level), 32'd0);

        // Reset mid-check with input held high through reset release
        in_async = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("midrst_level",  32'(level),  32'd0);
        check("midrst_rise",   32'(rise),   32'd0);
        check("midrst_fall",   32'(fall),   32'd0);
        check("midrst_events", 32'(events), 32'd0);
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("post_rst_rise_e%0d", e), 32'(rise), (e == 8) ? 32'd1 : 32'd0);
            check($sformatf("post_rst_level_e%0d", e), 32'(level), (e == 8) ? 32'd1 : 32'd0);
        end
        tick();
        check("post_rst_events", 32'(events), 32'd1);

        // Random bounce (runs of 1..3 cycles) for 200 cycles, then settle low
        r0 = n_rise;
        f0 = n_fall;
        cyc = 0;
        val = 1'b0;
        while (cyc < 200) begin
            int hold;
            hold = $urandom_range(3, 1);
            in_async = val;
            repeat (hold) tick();
            cyc += hold;
            val = ~val;
        end
        in_async = 1'b0;
        repeat (20) tick();
        check("bounce_rises", 32'(n_rise - r0), 32'd0);
        check("bounce_falls", 32'(n_fall - f0), 32'd1);
        check("bounce_level", 32'(level), 32'd0);
        check("bounce_events", 32'(events), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
